// File: rtl/gray_pkg.sv
// ============================================================================
// Module : gray_pkg
// Brief  : Shared defaults and output-slot state type for gray_conv_arb.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gray_pkg;
  localparam int NUM_REQ_DEFAULT = 4;
  localparam int WIDTH_DEFAULT   = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/bin2gray_cvt.sv
// ============================================================================
// Module : bin2gray_cvt
// Brief  : Purely combinational binary-to-Gray converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2gray_cvt #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);
  // MSB passes through; every lower bit is the XOR with its upper neighbour.
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

`default_nettype wire

// File: rtl/gray_conv_arb.sv
// ============================================================================
// Module : gray_conv_arb
// Brief  : Round-robin arbiter feeding one shared binary-to-Gray converter
//          into a single registered output slot with valid/ready handshake.
//          Optional macro GRAY_CONV_ARB_CHECK_EN adds a back-conversion check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_conv_arb
  import gray_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_gray,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       busy
`ifdef GRAY_CONV_ARB_CHECK_EN
  ,
  output logic                       chk_err
`endif
);
  localparam int IDW = $clog2(NUM_REQ);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_out_id;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW:0]     w_idx;
  logic             w_any;
  logic             w_slot_free;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_bin;
  logic [WIDTH-1:0] w_sel_gray;
  logic [WIDTH-1:0] r_out_gray;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW+1)'(NUM_REQ);
      end
      if (!w_any && req_valid[w_idx[IDW-1:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx[IDW-1:0];
      end
    end
  end

  // rst_n gates the grant so req_ready is low for the whole reset window.
  assign w_slot_free = (r_state == EMPTY) || out_ready;
  assign w_xfer      = rst_n && w_slot_free && w_any;
  assign req_ready   = w_xfer ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_sel_bin   = req_data[w_gnt_idx*WIDTH +: WIDTH];

  bin2gray_cvt #(
    .WIDTH (WIDTH)
  ) u_cvt (
    .i_bin  (w_sel_bin),
    .o_gray (w_sel_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_nxt = FULL;
      FULL: begin
        if (w_xfer)         w_state_nxt = FULL;
        else if (out_ready) w_state_nxt = EMPTY;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_gray <= '0;
      r_out_id   <= '0;
      r_rr_ptr   <= '0;
    end else if (w_xfer) begin
      r_out_gray <= w_sel_gray;
      r_out_id   <= w_gnt_idx;
      r_rr_ptr   <= (w_gnt_idx == IDW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  assign out_valid = (r_state == FULL);
  assign busy      = (r_state == FULL);
  assign out_gray  = r_out_gray;
  assign out_id    = r_out_id;

`ifdef GRAY_CONV_ARB_CHECK_EN
  logic [WIDTH-1:0] r_src_bin;
  logic [WIDTH-1:0] w_back_bin;
  logic             r_chk_err;

  // Binary bit k is the parity of Gray bits [WIDTH-1:k].
  always_comb begin
    w_back_bin = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_back_bin[k] = ^(out_gray >> k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_bin <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (w_xfer) r_src_bin <= w_sel_bin;
      r_chk_err <= (r_state == FULL) && (w_back_bin != r_src_bin);
    end
  end

  assign chk_err = r_chk_err;
`endif
endmodule

`default_nettype wire

// File: tb/tb_gray_conv_arb.sv
// ============================================================================
// Module : tb_gray_conv_arb
// Brief  : Directed self-checking bench for gray_conv_arb (4 x 4-bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gray_conv_arb;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_gray;
  logic [1:0]  out_id;
  logic        busy;
`ifdef GRAY_CONV_ARB_CHECK_EN
  logic        chk_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gray_conv_arb #(
    .NUM_REQ (4),
    .WIDTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .busy      (busy)
`ifdef GRAY_CONV_ARB_CHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_id [5];
  logic [3:0] exp_gr [5];
  logic [3:0] b;

  initial begin
    // Requester data {3:F, 2:8, 1:4, 0:3} -> Gray {1000, 1100, 0110, 0010}
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_gr = '{4'b0010, 4'b0110, 4'b1100, 4'b1000, 4'b0010};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 16'h0;
    out_ready = 1'b1;
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_gray",  32'(out_gray),  32'd0);
    check_eq("rst_out_id",    32'(out_id),    32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) tick();
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    tick();
    check_eq("idle_out_valid", 32'(out_valid), 32'd0);

    // Single conversion: 1011 -> 1110
    req_valid = 4'b0001;
    req_data  = 16'h000B;
    #1;
    check_eq("single_req_ready", 32'(req_ready), 32'b0001);
    tick();
    check_eq("single_out_valid", 32'(out_valid), 32'd1);
    check_eq("single_out_gray",  32'(out_gray),  32'b1110);
    check_eq("single_out_id",    32'(out_id),    32'd0);

    // Asynchronous reset pulse returns pointer to 0
    rst_n = 1'b0;
    #1;
    check_eq("pulse_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    // Continuous requests, one result per cycle
    req_valid = 4'b1111;
    req_data  = 16'hF843;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("rr_req_ready", 32'(req_ready), 32'(4'b0001 << exp_id[i]));
      tick();
      check_eq("rr_out_valid", 32'(out_valid), 32'd1);
      check_eq("rr_out_id",    32'(out_id),    32'(exp_id[i]));
      check_eq("rr_out_gray",  32'(out_gray),  32'(exp_gr[i]));
    end

    // Drain to EMPTY, then load requester 1 (bin 0100 -> gray 0110); ptr -> 2
    req_valid = 4'b0000;
    tick();
    check_eq("drain_out_valid", 32'(out_valid), 32'd0);
    check_eq("drain_busy",      32'(busy),      32'd0);
    req_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    check_eq("load1_out_gray", 32'(out_gray), 32'b0110);
    check_eq("load1_busy",     32'(busy),     32'd1);

    // Back-pressure for 5 cycles: everything holds, no grant
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_out_gray",  32'(out_gray),  32'b0110);
      check_eq("stall_out_id",    32'(out_id),    32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_req_ready", 32'(req_ready), 32'b0100);
    tick();
    check_eq("release_out_valid", 32'(out_valid), 32'd1);
    check_eq("release_out_id",    32'(out_id),    32'd2);
    check_eq("release_out_gray",  32'(out_gray),  32'b1100);

    // Pointer now 3: requester 1 alone, wrapping past 3 and 0 -> ptr 2
    req_valid = 4'b0010;
    #1;
    check_eq("wrap_req_ready", 32'(req_ready), 32'b0010);
    tick();
    // Only 1 and 3 valid with ptr 2 -> grant 3, then 1
    req_valid = 4'b1010;
    #1;
    check_eq("sparse_first_ready", 32'(req_ready), 32'b1000);
    tick();
    check_eq("sparse_first_id", 32'(out_id), 32'd3);
    #1;
    check_eq("sparse_second_ready", 32'(req_ready), 32'b0010);
    tick();
    check_eq("sparse_second_id",   32'(out_id),   32'd1);
    check_eq("sparse_second_gray", 32'(out_gray), 32'b0110);

    // Exhaustive sweep through requester 0
    req_valid = 4'b0001;
    for (int v = 0; v < 16; v++) begin
      b = 4'(v);
      req_data = {12'h000, b};
      tick();
      check_eq("sweep_gray", 32'(out_gray), 32'(b ^ (b >> 1)));
`ifdef GRAY_CONV_ARB_CHECK_EN
      check_eq("sweep_chk_err", 32'(chk_err), 32'd0);
`endif
    end
    req_data = 16'h0008;
    tick();
    check_eq("gray_1000", 32'(out_gray), 32'b1100);
    req_data = 16'h000F;
    tick();
    check_eq("gray_1111", 32'(out_gray), 32'b1000);

`ifdef GRAY_CONV_ARB_CHECK_EN
    out_ready = 1'b0;
    tick();
    force dut.out_gray = 4'b1001;
    tick();
    release dut.out_gray;
    check_eq("chk_err_set", 32'(chk_err), 32'd1);
    tick();
    check_eq("chk_err_clear", 32'(chk_err), 32'd0);
    out_ready = 1'b1;
`endif

    // Reset asserted mid-cycle while FULL
    req_valid = 4'b1111;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_busy",      32'(busy),      32'd0);
    check_eq("async_out_gray",  32'(out_gray),  32'd0);
    check_eq("async_req_ready", 32'(req_ready), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    check_eq("post_rst_id",    32'(out_id),    32'd0);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/gray_conv_arb.md
GRAY_CONV_ARB -- requirements
Module: gray_conv_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the converter (2..8).
REQ-002 SHALL have parameter WIDTH, default 4, binary/Gray word width in bits (2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester word-valid.
REQ-006 SHALL have port req_data  input  NUM_REQ*WIDTH  binary words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer when req_valid[i] && req_ready[i].
REQ-008 SHALL have port out_valid  output  1  registered result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accept.
REQ-010 SHALL have port out_gray  output  WIDTH  Gray code of the granted word.
REQ-011 SHALL have port out_id  output  $clog2(NUM_REQ)  index of the requester that produced out_gray.
REQ-012 SHALL have port busy  output  1  high while the output slot is FULL.

Function
REQ-013 SHALL convert as gray[WIDTH-1] = bin[WIDTH-1], gray[k] = bin[k+1] XOR bin[k] for k < WIDTH-1.
REQ-014 SHALL implement a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL define slot_free = EMPTY or (FULL and out_ready).
REQ-016 SHALL assert req_ready only when slot_free and at least one req_valid, for exactly one requester: the first valid index at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-017 SHALL, on a transfer from requester g, load out_gray/out_id on the next edge (latency 1 cycle), go/stay FULL, and set rr_ptr = (g+1) mod NUM_REQ.
REQ-018 SHALL, in FULL with out_ready=1 and no transfer, go EMPTY; with out_ready=0, hold out_gray/out_id/out_valid stable.
REQ-019 SHALL sustain one result per cycle when out_ready stays high and requests are continuous (simultaneous drain and load).
REQ-020 SHALL leave rr_ptr unchanged on cycles with no transfer.
REQ-021 SHALL make req_ready depend combinationally on req_valid, rr_ptr, state and out_ready only; never on req_data.
REQ-022 SHALL treat a requester dropping req_valid before grant as no request (no grant, no pointer change).

Reset
REQ-023 SHALL, while rst_n=0, force state=EMPTY, out_valid=0, out_gray=0, out_id=0, busy=0, rr_ptr=0, req_ready=0, independent of clk.
REQ-024 SHALL discard any held result on reset mid-operation; first post-reset grant goes to lowest valid index.

Configuration
REQ-025 SHALL support macro GRAY_CONV_ARB_CHECK_EN: when defined, add output chk_err (1 bit) and a Gray-to-binary back-conversion of out_gray compared with the registered source word; chk_err registered, high one cycle after any FULL cycle with mismatch, reset 0.
REQ-026 SHALL, without GRAY_CONV_ARB_CHECK_EN, have no chk_err port and no source-word register; all other behaviour identical.

Structure
REQ-027 SHALL place the NUM_REQ/WIDTH defaults and the FSM state typedef (EMPTY, FULL) in shared package gray_pkg.
REQ-028 SHALL instantiate the pure combinational converter as sub-module bin2gray_cvt (parameter WIDTH), one instance shared by all requesters.

Verification
REQ-029 SHALL test: reset, then req_valid=4'b0001, req_data[3:0]=4'b1011, out_ready=1 -> next cycle out_valid=1, out_gray=4'b1110, out_id=0.
REQ-030 SHALL test: all four valid continuously, out_ready=1 -> grants cycle 0,1,2,3,0 one per cycle, out_id sequence 0,1,2,3,0.
REQ-031 SHALL test: FULL with out_gray=4'b0110, out_ready=0 for 5 cycles -> outputs stable, req_ready=0, then out_ready=1 -> same-cycle new grant, no bubble.
REQ-032 SHALL test: only requesters 1 and 3 valid, rr_ptr=2 -> grant 3, then 1; exhaustive sweep bin 0..15 -> gray matches REQ-013 (e.g. 4'b1000 -> 4'b1100, 4'b1111 -> 4'b1000).
REQ-033 SHALL test: rst_n low mid-FULL, asynchronous to clk -> out_valid=0 immediately, rr_ptr=0 after release.
REQ-034 SHALL test (GRAY_CONV_ARB_CHECK_EN): forced out_gray bit flip -> chk_err=1 for one cycle; no force -> chk_err=0 across full sweep.
